// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared state encoding, owner indices and error-data default for the SDRAM arbiter
package sdram_arb_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    SETTLE  = 2'd2,
    WAIT_RD = 2'd3
  } state_t;
  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;
  localparam logic OWNER0 = 1'b0;
  localparam logic OWNER1 = 1'b1;
endpackage

// File: rtl/sdram_arbiter_rr_arb2.sv
// rr_arb2: combinational two-request round-robin picker; a lone request wins, a tie goes to the port that is not rr_last
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       rr_last,
  output logic       grant,
  output logic       owner
);
  assign grant = |valid;
  assign owner = &valid ? ~rr_last : valid[1];
endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: round-robin sharing of one SDRAM controller user port between two requesters, with read watchdog and sticky error flags
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int                ADDR_W   = 23,
  parameter int                DATA_W   = 32,
  parameter int                RD_BEATS = 1,
  parameter int                TIMEOUT  = 1023,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic              req0_rw,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_rvalid,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  input  logic              req1_rw,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_rvalid,
  output logic [DATA_W-1:0] req1_rdata,
  output logic [ADDR_W-1:0] sd_user_addr,
  output logic              sd_rw,
  output logic [DATA_W-1:0] sd_data_in,
  output logic              sd_in_valid,
  input  logic              sd_busy,
  input  logic [DATA_W-1:0] sd_data_out,
  input  logic              sd_out_valid,
  output logic              err_timeout,
  output logic              err_stray,
  input  logic              err_clr
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int BW = $clog2(RD_BEATS + 1);
  state_t state, state_d;
  logic rr_last, owner, grant, pick;
  logic take, issue, real_beat, err_beat, beat_v;
  logic [BW-1:0] beat;
  logic [TW-1:0] tcnt;
  logic [DATA_W-1:0] beat_data;
  rr_arb2 u_arb (
    .valid   ({req1_valid, req0_valid}),
    .rr_last (rr_last),
    .grant   (grant),
    .owner   (pick)
  );
  assign beat_v    = real_beat | err_beat;
  assign beat_data = real_beat ? sd_data_out : ERR_DATA;
  always_comb begin
    state_d   = state;
    take      = 1'b0;
    issue     = 1'b0;
    real_beat = 1'b0;
    err_beat  = 1'b0;
    case (state)
      IDLE: if (grant) begin
        take    = 1'b1;
        state_d = ISSUE;
      end
      ISSUE: if (!sd_busy) begin
        issue   = 1'b1;
        state_d = SETTLE;
      end
      SETTLE: state_d = sd_rw ? IDLE : WAIT_RD;
      WAIT_RD: begin
        real_beat = sd_out_valid;
        err_beat  = !sd_out_valid && tcnt == TW'(TIMEOUT);
        if ((real_beat || err_beat) && beat == BW'(RD_BEATS - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rr_last      <= OWNER1;
      owner        <= OWNER0;
      beat         <= '0;
      tcnt         <= '0;
      req0_ready   <= 1'b0;
      req1_ready   <= 1'b0;
      req0_rvalid  <= 1'b0;
      req1_rvalid  <= 1'b0;
      req0_rdata   <= '0;
      req1_rdata   <= '0;
      sd_user_addr <= '0;
      sd_rw        <= 1'b0;
      sd_data_in   <= '0;
      sd_in_valid  <= 1'b0;
      err_timeout  <= 1'b0;
      err_stray    <= 1'b0;
    end else begin
      state       <= state_d;
      req0_ready  <= take && pick == OWNER0;
      req1_ready  <= take && pick == OWNER1;
      sd_in_valid <= issue;
      if (take) begin
        rr_last      <= pick;
        owner        <= pick;
        sd_user_addr <= pick ? req1_addr : req0_addr;
        sd_rw        <= pick ? req1_rw : req0_rw;
        sd_data_in   <= pick ? req1_wdata : req0_wdata;
      end
      beat <= state == SETTLE ? '0 : beat + BW'(beat_v);
      tcnt <= state == SETTLE ? '0 : (state == WAIT_RD && tcnt != TW'(TIMEOUT)) ? tcnt + 1'b1 : tcnt;
      req0_rvalid <= beat_v && owner == OWNER0;
      req1_rvalid <= beat_v && owner == OWNER1;
      if (beat_v && owner == OWNER0) req0_rdata <= beat_data;
      if (beat_v && owner == OWNER1) req1_rdata <= beat_data;
      err_timeout <= err_beat | (err_timeout & ~err_clr);
      err_stray   <= (sd_out_valid && state != WAIT_RD) | (err_stray & ~err_clr);
    end
  end
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed self-checking bench for sdram_arbiter (main instance RD_BEATS=1, second instance RD_BEATS=2 TIMEOUT=15)
module tb_sdram_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0_valid, req0_rw, req1_valid, req1_rw;
  logic [22:0] req0_addr, req1_addr;
  logic [31:0] req0_wdata, req1_wdata;
  logic sd_busy, sd_out_valid, err_clr;
  logic [31:0] sd_data_out;
  logic req0_ready, req0_rvalid, req1_ready, req1_rvalid;
  logic [31:0] req0_rdata, req1_rdata, sd_data_in;
  logic [22:0] sd_user_addr;
  logic sd_rw, sd_in_valid, err_timeout, err_stray;
  logic b_req0_ready, b_req0_rvalid, b_req1_ready, b_req1_rvalid;
  logic [31:0] b_req0_rdata, b_req1_rdata, b_sd_data_in;
  logic [22:0] b_sd_user_addr;
  logic b_sd_rw, b_sd_in_valid, b_err_timeout, b_err_stray;
  int passed = 0;
  int total = 0;
  always #5 clk = ~clk;
  sdram_arbiter #(.RD_BEATS(1), .TIMEOUT(1023)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_rw(req0_rw), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready), .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_rw(req1_rw), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready), .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
    .sd_user_addr(sd_user_addr), .sd_rw(sd_rw), .sd_data_in(sd_data_in), .sd_in_valid(sd_in_valid),
    .sd_busy(sd_busy), .sd_data_out(sd_data_out), .sd_out_valid(sd_out_valid),
    .err_timeout(err_timeout), .err_stray(err_stray), .err_clr(err_clr)
  );
  sdram_arbiter #(.RD_BEATS(2), .TIMEOUT(15)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_rw(req0_rw), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(b_req0_ready), .req0_rvalid(b_req0_rvalid), .req0_rdata(b_req0_rdata),
    .req1_valid(req1_valid), .req1_rw(req1_rw), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(b_req1_ready), .req1_rvalid(b_req1_rvalid), .req1_rdata(b_req1_rdata),
    .sd_user_addr(b_sd_user_addr), .sd_rw(b_sd_rw), .sd_data_in(b_sd_data_in), .sd_in_valid(b_sd_in_valid),
    .sd_busy(sd_busy), .sd_data_out(sd_data_out), .sd_out_valid(sd_out_valid),
    .err_timeout(b_err_timeout), .err_stray(b_err_stray), .err_clr(err_clr)
  );
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic test_reset();
    logic [140:0] outs;
    rst_n = 1'b0;
    tick();
    outs = {req0_ready, req0_rvalid, req0_rdata, req1_ready, req1_rvalid, req1_rdata,
            sd_user_addr, sd_rw, sd_data_in, sd_in_valid, err_timeout, err_stray};
    total++;
    if (outs !== '0) $display("FAIL reset_outputs got %h want 0", outs);
    else passed++;
    rst_n = 1'b1;
    tick();
    total++;
    if ({req0_ready, req1_ready, sd_in_valid} !== 3'b000) $display("FAIL idle_no_grant got %b want 000", {req0_ready, req1_ready, sd_in_valid});
    else passed++;
  endtask
  task automatic test_write();
    logic rv;
    req0_valid = 1'b1; req0_rw = 1'b1; req0_addr = 23'h000123; req0_wdata = 32'hA5A5_0001;
    tick();
    rv = req0_rvalid | req1_rvalid;
    total++;
    if ({req0_ready, req1_ready, sd_in_valid} !== 3'b100) $display("FAIL wr_ready got %b want 100", {req0_ready, req1_ready, sd_in_valid});
    else passed++;
    req0_valid = 1'b0;
    tick();
    rv |= req0_rvalid | req1_rvalid;
    total++;
    if ({sd_in_valid, sd_rw, sd_user_addr, sd_data_in} !== {1'b1, 1'b1, 23'h000123, 32'hA5A5_0001})
      $display("FAIL wr_issue got %b %b %h %h want 1 1 000123 a5a50001", sd_in_valid, sd_rw, sd_user_addr, sd_data_in);
    else passed++;
    total++;
    if (req0_ready !== 1'b0) $display("FAIL wr_ready_width got %b want 0", req0_ready);
    else passed++;
    tick();
    rv |= req0_rvalid | req1_rvalid;
    total++;
    if (sd_in_valid !== 1'b0) $display("FAIL wr_in_valid_width got %b want 0", sd_in_valid);
    else passed++;
    total++;
    if (rv !== 1'b0) $display("FAIL wr_no_rvalid got %b want 0", rv);
    else passed++;
  endtask
  task automatic test_read();
    logic rv;
    req1_valid = 1'b1; req1_rw = 1'b0; req1_addr = 23'h000400; req1_wdata = 32'h0;
    tick();
    total++;
    if ({req0_ready, req1_ready} !== 2'b01) $display("FAIL rd_ready got %b want 01", {req0_ready, req1_ready});
    else passed++;
    req1_valid = 1'b0;
    tick();
    total++;
    if ({sd_in_valid, sd_rw, sd_user_addr} !== {1'b1, 1'b0, 23'h000400})
      $display("FAIL rd_issue got %b %b %h want 1 0 000400", sd_in_valid, sd_rw, sd_user_addr);
    else passed++;
    rv = 1'b0;
    repeat (9) begin
      tick();
      rv |= req0_rvalid | req1_rvalid;
    end
    sd_out_valid = 1'b1; sd_data_out = 32'h1234_5678;
    tick();
    sd_out_valid = 1'b0; sd_data_out = 32'h0;
    total++;
    if ({rv, req0_rvalid, req1_rvalid, req1_rdata} !== {1'b0, 1'b0, 1'b1, 32'h1234_5678})
      $display("FAIL rd_beat got early=%b r0=%b r1=%b data=%h want 0 0 1 12345678", rv, req0_rvalid, req1_rvalid, req1_rdata);
    else passed++;
    tick();
    total++;
    if ({req1_rvalid, err_stray, err_timeout} !== 3'b000) $display("FAIL rd_after got %b want 000", {req1_rvalid, err_stray, err_timeout});
    else passed++;
  endtask
  task automatic test_contention();
    logic [5:0] seq = '0;
    logic [31:0] sent = '0;
    int g = 0, r0 = 0, r1 = 0, cd = 0, bad = 0, n = 0;
    req0_rw = 1'b0; req1_rw = 1'b0; req0_addr = 23'h000100; req1_addr = 23'h000200;
    req0_valid = 1'b1; req1_valid = 1'b1;
    while ((g < 6 || r0 + r1 < 6) && n < 300) begin
      tick();
      n++;
      if (req0_rvalid) begin r0++; if (req0_rdata !== sent) bad++; end
      if (req1_rvalid) begin r1++; if (req1_rdata !== sent) bad++; end
      if (req0_ready && req1_ready) bad++;
      if (req0_ready || req1_ready) begin
        if (g < 6) seq[g] = req1_ready;
        g++;
        if (g == 6) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      end
      sd_out_valid = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin sent = sent + 32'h11; sd_data_out = sent; sd_out_valid = 1'b1; end
      end
      if (sd_in_valid) cd = 2;
    end
    sd_out_valid = 1'b0;
    repeat (4) tick();
    total++;
    if (seq !== 6'b101010) $display("FAIL rr_order got %b want 101010", seq);
    else passed++;
    total++;
    if (r0 != 3 || r1 != 3 || g != 6) $display("FAIL rr_counts got r0=%0d r1=%0d grants=%0d want 3 3 6", r0, r1, g);
    else passed++;
    total++;
    if (bad != 0) $display("FAIL rr_data got %0d bad beats want 0", bad);
    else passed++;
  endtask
  task automatic test_busy();
    int bad = 0, n = 0;
    sd_busy = 1'b1;
    req0_valid = 1'b1; req0_rw = 1'b1; req0_addr = 23'h0002AA; req0_wdata = 32'h0000_0055;
    do begin tick(); n++; end while (!req0_ready && n < 20);
    total++;
    if (req0_ready !== 1'b1) $display("FAIL busy_ready got %b want 1", req0_ready);
    else passed++;
    req0_valid = 1'b0;
    repeat (20) begin
      tick();
      if ({sd_in_valid, sd_rw, sd_user_addr, sd_data_in} !== {1'b0, 1'b1, 23'h0002AA, 32'h55}) bad++;
    end
    total++;
    if (bad != 0) $display("FAIL busy_stall got %0d bad cycles want 0", bad);
    else passed++;
    sd_busy = 1'b0;
    tick();
    total++;
    if ({sd_in_valid, sd_rw, sd_user_addr, sd_data_in} !== {1'b1, 1'b1, 23'h0002AA, 32'h55})
      $display("FAIL busy_issue got %b %b %h %h want 1 1 0002aa 00000055", sd_in_valid, sd_rw, sd_user_addr, sd_data_in);
    else passed++;
    repeat (2) tick();
  endtask
  task automatic test_timeout();
    int n = 0, k = 2;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    total++;
    if (b_err_timeout !== 1'b0) $display("FAIL to_clear_start got %b want 0", b_err_timeout);
    else passed++;
    req0_valid = 1'b1; req0_rw = 1'b0; req0_addr = 23'h000010;
    do begin tick(); n++; end while (!b_req0_ready && n < 20);
    total++;
    if (b_req0_ready !== 1'b1) $display("FAIL to_ready got %b want 1", b_req0_ready);
    else passed++;
    req0_valid = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!b_sd_in_valid && n < 20);
    total++;
    if (b_sd_in_valid !== 1'b1) $display("FAIL to_issue got %b want 1", b_sd_in_valid);
    else passed++;
    tick();
    sd_out_valid = 1'b1; sd_data_out = 32'h1;
    tick();
    sd_out_valid = 1'b0; sd_data_out = 32'h0;
    total++;
    if ({b_req0_rvalid, b_req0_rdata, b_err_timeout} !== {1'b1, 32'h1, 1'b0})
      $display("FAIL to_beat1 got %b %h %b want 1 00000001 0", b_req0_rvalid, b_req0_rdata, b_err_timeout);
    else passed++;
    do begin tick(); k++; end while (!b_req0_rvalid && k < 40);
    total++;
    if (k != 17) $display("FAIL to_latency got %0d want 17", k);
    else passed++;
    total++;
    if ({b_req0_rvalid, b_req0_rdata, b_err_timeout, b_req1_rvalid} !== {1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0})
      $display("FAIL to_errbeat got %b %h %b %b want 1 deadbeef 1 0", b_req0_rvalid, b_req0_rdata, b_err_timeout, b_req1_rvalid);
    else passed++;
    tick();
    total++;
    if ({b_req0_rvalid, b_err_timeout} !== 2'b01) $display("FAIL to_sticky got %b want 01", {b_req0_rvalid, b_err_timeout});
    else passed++;
    repeat (3) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    total++;
    if (b_err_timeout !== 1'b0) $display("FAIL to_clr got %b want 0", b_err_timeout);
    else passed++;
  endtask
  task automatic test_stray();
    logic [140:0] outs;
    int n = 0;
    req1_valid = 1'b1; req1_rw = 1'b0; req1_addr = 23'h000040;
    do begin tick(); n++; end while (!req1_ready && n < 20);
    total++;
    if (req1_ready !== 1'b1) $display("FAIL st_ready got %b want 1", req1_ready);
    else passed++;
    req1_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    outs = {req0_ready, req0_rvalid, req0_rdata, req1_ready, req1_rvalid, req1_rdata,
            sd_user_addr, sd_rw, sd_data_in, sd_in_valid, err_timeout, err_stray};
    total++;
    if (outs !== '0) $display("FAIL st_reset_outputs got %h want 0", outs);
    else passed++;
    tick();
    rst_n = 1'b1;
    tick();
    sd_out_valid = 1'b1; sd_data_out = 32'h777;
    tick();
    sd_out_valid = 1'b0;
    total++;
    if ({err_stray, req0_rvalid, req1_rvalid} !== 3'b100) $display("FAIL st_flag got %b want 100", {err_stray, req0_rvalid, req1_rvalid});
    else passed++;
    sd_out_valid = 1'b1; err_clr = 1'b1;
    tick();
    sd_out_valid = 1'b0; err_clr = 1'b0;
    total++;
    if (err_stray !== 1'b1) $display("FAIL st_set_wins got %b want 1", err_stray);
    else passed++;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    total++;
    if (err_stray !== 1'b0) $display("FAIL st_clr got %b want 0", err_stray);
    else passed++;
  endtask
  initial begin
    req0_valid = 1'b0; req0_rw = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_rw = 1'b0; req1_addr = '0; req1_wdata = '0;
    sd_busy = 1'b0; sd_out_valid = 1'b0; sd_data_out = '0; err_clr = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_contention();
    test_busy();
    test_timeout();
    test_stray();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog got hang want finish");
    $fatal(1, "watchdog");
  end
endmodule
